ifu_fetch: RTL and testbench

Instruction fetch unit for the NPC core. It owns the PC and issues single-outstanding word fetches to instruction memory. Fetched words are buffered in a small FIFO and presented downstream with a valid/ready handshake; the downstream consumer is decode and the simulation monitor that ends the run on `ebreak`. It supports control-flow redirects and, optionally, self-halts after fetching `ebreak`.

---
 rtl/ifu_fetch.sv | 167 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues single-outstanding word fetches and buffers results in a FIFO.
// Optional feature macro IFU_EBREAK_HALT_EN: stop fetching after a non-dropped ebreak response.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        halted
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        reqPc_q, reqPc_d;
  logic               drop_q, drop_d;
  logic               reqValid_q, reqValid_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        bufData_q [BUF_DEPTH];
  logic [31:0]        bufPc_q   [BUF_DEPTH];

  logic reqFire;
  logic rspFire;
  logic redirectFire;
  logic push;
  logic pop;

  assign reqFire      = reqValid_q & imem_req_ready;
  assign rspFire      = imem_rsp_valid & (state_q == ST_WAIT);
  assign redirectFire = redirect_valid & (state_q != ST_HALT);
  // A flush wins over a push landing in the same cycle.
  assign push         = rspFire & ~drop_q & ~redirectFire;
  assign pop          = inst_valid & inst_ready;

`ifdef IFU_EBREAK_HALT_EN
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  logic halted_q, halted_d;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    reqPc_d  = reqPc_q;
    drop_d   = drop_q;
    rdPtr_d  = rdPtr_q;
    wrPtr_d  = wrPtr_q;
    count_d  = count_q;

    case (state_q)
      ST_REQ: begin
        if (reqFire) begin
          reqPc_d = pc_q;
          pc_d    = pc_q + 32'd4;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rspFire) begin
          drop_d  = 1'b0;
          state_d = ST_REQ;
`ifdef IFU_EBREAK_HALT_EN
          if (push && (imem_rsp_data == EBREAK)) begin
            state_d = ST_HALT;
          end
`endif
        end
      end
      default: ;
    endcase

    // A redirect only needs to poison a response that is still in flight after this edge.
    if (redirectFire) begin
      pc_d   = redirect_pc & ~32'h3;
      drop_d = (state_d == ST_WAIT);
    end

    if (redirectFire) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    reqValid_d = (state_d == ST_REQ) && (count_d < DEPTH_C);
`ifdef IFU_EBREAK_HALT_EN
    halted_d = (state_d == ST_HALT);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      reqPc_q    <= '0;
      drop_q     <= 1'b0;
      reqValid_q <= 1'b1;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
`ifdef IFU_EBREAK_HALT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      reqPc_q    <= reqPc_d;
      drop_q     <= drop_d;
      reqValid_q <= reqValid_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
`ifdef IFU_EBREAK_HALT_EN
      halted_q   <= halted_d;
`endif
    end
  end

  // Storage needs no reset: the head is only exposed while the count is non-zero.
  always_ff @(posedge clock) begin
    if (push) begin
      bufData_q[wrPtr_q] <= imem_rsp_data;
      bufPc_q[wrPtr_q]   <= reqPc_q;
    end
  end

  assign imem_req_valid = reqValid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (count_q != '0);
  assign inst           = inst_valid ? bufData_q[rdPtr_q] : 32'd0;
  assign inst_pc        = inst_valid ? bufPc_q[rdPtr_q]   : 32'd0;

`ifdef IFU_EBREAK_HALT_EN
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios followed by randomized memory/redirect traffic
// checked against a stream-level model (delivered PCs run consecutively from reset or the last redirect).
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        halted;

  ifu_fetch #(
    .RESET_PC (RESET_PC),
    .BUF_DEPTH(2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          memAlwaysReady;
  int          latMin = 1;
  int          latMax = 1;
  int          readyPct = 100;
  bit          redirectNow;
  logic [31:0] redirectTarget;
  bit          tbHalted;
  bit          specialEn;
  logic [31:0] specialAddr;
  bit          pend;
  logic [31:0] pendAddr;
  int          pendDelay;
  logic [31:0] expPc;
  logic [31:0] reqAddrLog[$];
  int          reqCycLog[$];
  int          popCycLog[$];
  bit          expectEmptyNext;
  bit          prevStall;
  logic [31:0] prevInst;
  logic [31:0] prevPc;

  // Memory contents are a fixed function of the address, with one optional ebreak slot.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (specialEn && (a == specialAddr)) return EBREAK;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyReset();
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rstReqValid", imem_req_valid, 1);
    checkOutput("rstReqAddr", imem_req_addr, RESET_PC);
    checkOutput("rstInstValid", inst_valid, 0);
    checkOutput("rstInst", inst, 0);
    checkOutput("rstInstPc", inst_pc, 0);
    checkOutput("rstHalted", halted, 0);
    reset           = 1'b0;
    pend            = 1'b0;
    expPc           = RESET_PC;
    tbHalted        = 1'b0;
    expectEmptyNext = 1'b0;
    prevStall       = 1'b0;
    redirectNow     = 1'b0;
    reqAddrLog.delete();
    reqCycLog.delete();
    popCycLog.delete();
  endtask

  // One clock cycle: drive memory/consumer/redirect, check against the model, then advance.
  task automatic applyStimulus();
    bit rspNow;
    bit applyRedirect;
    @(negedge clock);
    imem_req_ready = memAlwaysReady ? 1'b1 : ($urandom_range(0, 99) < 70);
    rspNow         = pend && (pendDelay == 0);
    imem_rsp_valid = rspNow;
    imem_rsp_data  = rspNow ? memWord(pendAddr) : $urandom;
    if (pend && !rspNow) pendDelay--;
    if (rspNow) pend = 1'b0;
    inst_ready     = ($urandom_range(0, 99) < readyPct);
    redirect_valid = redirectNow;
    redirect_pc    = redirectNow ? redirectTarget : $urandom;
    applyRedirect  = redirectNow && !tbHalted;
    #1;
    if (expectEmptyNext) checkOutput("flushEmpty", inst_valid, 0);
    if (prevStall) begin
      checkOutput("holdInst", inst, prevInst);
      checkOutput("holdPc", inst_pc, prevPc);
    end
    if (imem_req_valid) checkOutput("singleOutstanding", pend, 0);
    if (inst_valid && inst_ready) begin
      checkOutput("popPc", inst_pc, expPc);
      checkOutput("popInst", inst, memWord(expPc));
      expPc += 32'd4;
      popCycLog.push_back(cyc);
    end
    if (imem_req_valid && imem_req_ready) begin
      reqAddrLog.push_back(imem_req_addr);
      reqCycLog.push_back(cyc);
      pend      = 1'b1;
      pendAddr  = imem_req_addr;
      pendDelay = int'($urandom_range(latMin, latMax)) - 1;
    end
    if (applyRedirect) expPc = redirectTarget & ~32'h3;
    expectEmptyNext = applyRedirect;
    prevStall       = inst_valid && !inst_ready && !applyRedirect;
    prevInst        = inst;
    prevPc          = inst_pc;
    redirectNow     = 1'b0;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int popsBefore;
    bit found;
    specialEn   = 1'b0;
    specialAddr = '0;

    // Straight-line fetch with an always-ready, 1-cycle memory.
    applyReset();
    memAlwaysReady = 1'b1; latMin = 1; latMax = 1; readyPct = 100;
    repeat (8) applyStimulus();
    checkOutput("seqReqCount", reqAddrLog.size() >= 3, 1);
    if (reqAddrLog.size() >= 3) begin
      checkOutput("seqReq0", reqAddrLog[0], 32'h8000_0000);
      checkOutput("seqReq1", reqAddrLog[1], 32'h8000_0004);
      checkOutput("seqReq2", reqAddrLog[2], 32'h8000_0008);
      checkOutput("seqReqGap", reqCycLog[1] - reqCycLog[0], 2);
    end
    checkOutput("seqPopCount", popCycLog.size() >= 2, 1);
    if (popCycLog.size() >= 2 && reqCycLog.size() >= 1) begin
      checkOutput("seqFirstLatency", popCycLog[0] - reqCycLog[0], 2);
      checkOutput("seqPopGap", popCycLog[1] - popCycLog[0], 2);
    end

    // Back-pressure: buffer fills to two entries and fetching stops.
    applyReset();
    readyPct = 0;
    repeat (10) applyStimulus();
    checkOutput("bpReqCount", reqAddrLog.size(), 2);
    checkOutput("bpReqValid", imem_req_valid, 0);
    checkOutput("bpHeadValid", inst_valid, 1);
    checkOutput("bpHeadPc", inst_pc, RESET_PC);
    readyPct = 100;
    repeat (12) applyStimulus();
    checkOutput("bpDrained", popCycLog.size() >= 4, 1);
    checkOutput("bpResumed", reqAddrLog.size() > 2, 1);

    // Redirect while a response is outstanding.
    applyReset();
    latMin = 3; latMax = 3;
    applyStimulus();
    redirectNow = 1'b1; redirectTarget = 32'h8000_0102;
    applyStimulus();
    for (int i = 0; i < 10 && reqAddrLog.size() < 2; i++) applyStimulus();
    checkOutput("redirReqSeen", reqAddrLog.size(), 2);
    if (reqAddrLog.size() >= 2) checkOutput("redirReqAddr", reqAddrLog[1], 32'h8000_0100);
    checkOutput("redirDropEmpty", inst_valid, 0);
    repeat (8) applyStimulus();

    // ebreak at 8000_000C.
    applyReset();
    latMin = 1; latMax = 1;
    specialEn = 1'b1; specialAddr = 32'h8000_000C;
    repeat (14) applyStimulus();
`ifdef IFU_EBREAK_HALT_EN
    tbHalted = 1'b1;
    checkOutput("haltReqCount", reqAddrLog.size(), 4);
    checkOutput("haltPops", popCycLog.size(), 4);
    checkOutput("haltFlag", halted, 1);
    redirectNow = 1'b1; redirectTarget = 32'h8000_0200;
    repeat (5) applyStimulus();
    checkOutput("haltRedirIgnored", reqAddrLog.size(), 4);
    checkOutput("haltStays", halted, 1);
    checkOutput("haltReqValid", imem_req_valid, 0);
`else
    checkOutput("ebreakFetchOn", reqAddrLog.size() >= 5, 1);
    if (reqAddrLog.size() >= 5) checkOutput("ebreakNextAddr", reqAddrLog[4], 32'h8000_0010);
    checkOutput("ebreakNoHalt", halted, 0);
`endif
    specialEn = 1'b0;

    // Stale response after a reset taken mid-WAIT.
    applyReset();
    latMin = 3; latMax = 3;
    applyStimulus();
    applyStimulus();
    applyReset();
    @(negedge clock);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    inst_ready     = 1'b1;
    @(negedge clock);
    imem_rsp_valid = 1'b0;
    #1;
    checkOutput("staleIgnored", inst_valid, 0);
    checkOutput("staleReqValid", imem_req_valid, 1);
    checkOutput("staleReqAddr", imem_req_addr, RESET_PC);
    latMin = 1; latMax = 1;
    repeat (4) applyStimulus();
    checkOutput("stalePops", popCycLog.size() >= 1, 1);

    // Redirect coinciding with a pop and a response.
    applyReset();
    latMin = 2; latMax = 2; readyPct = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pend && (pendDelay == 0) && inst_valid) begin
        found = 1'b1;
        break;
      end
      applyStimulus();
    end
    checkOutput("coincSetup", found, 1);
    popsBefore = popCycLog.size();
    readyPct = 100;
    redirectNow = 1'b1; redirectTarget = 32'h8000_0300;
    applyStimulus();
    checkOutput("coincPopCounted", popCycLog.size(), popsBefore + 1);
    applyStimulus();
    repeat (8) applyStimulus();
    checkOutput("coincResume", popCycLog.size() > popsBefore + 1, 1);

    // Randomized traffic with sporadic redirects.
    applyReset();
    memAlwaysReady = 1'b0; latMin = 1; latMax = 4; readyPct = 60;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        redirectNow    = 1'b1;
        redirectTarget = 32'h8000_0000 + $urandom_range(0, 4095);
      end
      applyStimulus();
    end
    checkOutput("randomProgress", popCycLog.size() > 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
